// File: rtl/bufg_clr_seq.sv
`default_nettype none
// ============================================================================
// Module      : bufg_clr_seq
// Description : Realignment sequencer for a bank of BUFGCE_DIV dividers.
//               When the MMCM/CDCM lock rises, or when realignment is requested
//               while running, every enabled channel has its CE held low for a
//               fixed window. A single CLR pulse is issued inside that window so
//               all dividers restart in phase. After a hold period the qualified
//               lock (mmcm_cdcm_locked_level2) is released.
//               Optional status outputs (relock_cnt, lock_lost) are compiled in
//               when the macro BUFG_CLR_SEQ_STATUS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module bufg_clr_seq #(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int CE_LOW_CYCLES = 5,
    parameter int CLR_OFFSET    = 2,
    parameter int LOCK_HOLD     = 2,
    parameter int OUT_PIPE      = 2
) (
    input  logic            clk_CLR,
    input  logic            rst,
    input  logic            mmcm_cdcm_locked,
    input  logic [N_CH-1:0] ch_en,
    input  logic            resync_req,
    output logic            resync_ack,
    output logic [N_CH-1:0] BUFDIV_CE,
    output logic [N_CH-1:0] BUFDIV_CLR,
    output logic            mmcm_cdcm_locked_level2,
    output logic            seq_busy
`ifdef BUFG_CLR_SEQ_STATUS_EN
    ,
    output logic [15:0]     relock_cnt,
    output logic            lock_lost
`endif
);

    // One counter serves both the gate window and the hold period, so it is
    // sized for whichever of the two is longer.
    localparam int c_MAX_CNT = (CE_LOW_CYCLES > LOCK_HOLD) ? CE_LOW_CYCLES : LOCK_HOLD;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_GATE_LAST = c_CNT_W'(CE_LOW_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(LOCK_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_CLR_IDX   = c_CNT_W'(CLR_OFFSET);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    // Lock synchroniser and edge detection
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_lock;
    logic                   r_lock_d;
    logic                   w_lock_rise;

    // Realignment request edge detection
    logic                   r_req;
    logic                   r_req_d;
    logic                   w_req_rise;

    // Sequencer
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_ack_nxt;
    logic [N_CH-1:0]        r_en_q;
    logic                   r_pend;
    logic                   r_run_q;
    logic                   r_busy;
    logic                   r_ack;

    // Per-channel gate/clear before the output pipeline
    logic [N_CH-1:0]        w_gate;
    logic [N_CH-1:0]        w_clr;
    logic [N_CH-1:0]        r_ce_pipe  [OUT_PIPE];
    logic [N_CH-1:0]        r_clr_pipe [OUT_PIPE];

    assign w_sync_lock = r_sync[SYNC_STAGES-1];
    assign w_lock_rise = w_sync_lock & ~r_lock_d;
    assign w_req_rise  = r_req & ~r_req_d;

    // Bring the raw lock into the clk_CLR domain and keep one delayed copy for edge detection.
    always_ff @(posedge clk_CLR or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_lock_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], mmcm_cdcm_locked};
            r_lock_d <= w_sync_lock;
        end
    end

    // Register the realignment request level so only its rising edge starts a sequence.
    always_ff @(posedge clk_CLR or posedge rst) begin
        if (rst) begin
            r_req   <= 1'b0;
            r_req_d <= 1'b0;
        end else begin
            r_req   <= resync_req;
            r_req_d <= r_req;
        end
    end

    // Next-state and counter decode; losing the synchronised lock aborts any active phase.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        w_ack_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_lock_rise) begin
                    w_state_nxt = ST_GATE;
                    w_capture   = 1'b1;
                end
            end
            ST_GATE: begin
                if (!w_sync_lock) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_GATE_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!w_sync_lock) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    // Only a sequence started by an accepted request is acknowledged.
                    w_ack_nxt   = r_pend;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (!w_sync_lock) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_req_rise) begin
                    w_state_nxt = ST_GATE;
                    w_capture   = 1'b1;
                    w_accept    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, captured channel mask and the status flags registered alongside the state.
    always_ff @(posedge clk_CLR or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_en_q  <= '0;
            r_pend  <= 1'b0;
            r_run_q <= 1'b0;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_en_q <= ch_en;
            end
            if (w_accept) begin
                r_pend <= 1'b1;
            end else if (w_ack_nxt || (w_state_nxt == ST_IDLE)) begin
                r_pend <= 1'b0;
            end
            r_run_q <= (w_state_nxt == ST_RUN);
            r_busy  <= (w_state_nxt == ST_GATE) || (w_state_nxt == ST_HOLD);
            r_ack   <= w_ack_nxt;
        end
    end

    // Gate every enabled channel for the whole window; clear it on one window index only.
    always_comb begin
        w_gate = '0;
        w_clr  = '0;
        if (r_state == ST_GATE) begin
            w_gate = r_en_q;
            if (r_cnt == c_CLR_IDX) begin
                w_clr = r_en_q;
            end
        end
    end

    // Fixed-latency output pipeline; reset drives CE and CLR low so dividers are stopped.
    always_ff @(posedge clk_CLR or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < OUT_PIPE; k++) begin
                r_ce_pipe[k]  <= '0;
                r_clr_pipe[k] <= '0;
            end
        end else begin
            r_ce_pipe[0]  <= ~w_gate;
            r_clr_pipe[0] <= w_clr;
            for (int k = 1; k < OUT_PIPE; k++) begin
                r_ce_pipe[k]  <= r_ce_pipe[k-1];
                r_clr_pipe[k] <= r_clr_pipe[k-1];
            end
        end
    end

    assign BUFDIV_CE  = r_ce_pipe[OUT_PIPE-1];
    assign BUFDIV_CLR = r_clr_pipe[OUT_PIPE-1];
    assign resync_ack = r_ack;
    assign seq_busy   = r_busy;

    // The raw lock term lets the qualified lock drop in the same cycle the MMCM loses lock.
    assign mmcm_cdcm_locked_level2 = mmcm_cdcm_locked & w_sync_lock & r_lock_d & r_run_q;

`ifdef BUFG_CLR_SEQ_STATUS_EN
    logic [15:0] r_relock_cnt;
    logic        r_lock_lost;

    // Count RUN entries (saturating) and remember any loss of lock while running.
    always_ff @(posedge clk_CLR or posedge rst) begin
        if (rst) begin
            r_relock_cnt <= '0;
            r_lock_lost  <= 1'b0;
        end else begin
            if ((r_state == ST_HOLD) && (w_state_nxt == ST_RUN) && (r_relock_cnt != 16'hFFFF)) begin
                r_relock_cnt <= r_relock_cnt + 16'd1;
            end
            if ((r_state == ST_RUN) && (w_state_nxt == ST_IDLE)) begin
                r_lock_lost <= 1'b1;
            end
        end
    end

    assign relock_cnt = r_relock_cnt;
    assign lock_lost  = r_lock_lost;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bufg_clr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bufg_clr_seq
// Description : Self-checking bench for bufg_clr_seq with randomised channel
//               masks and abort points, checked against a window-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bufg_clr_seq;

    localparam int N     = 4;
    localparam int SYNC  = 2;
    localparam int CEL   = 5;
    localparam int CO    = 2;
    localparam int LH    = 2;
    localparam int OP    = 2;
    localparam int NEVER = 1 << 30;

    logic          clk_CLR = 1'b0;
    logic          rst = 1'b0;
    logic          mmcm_cdcm_locked = 1'b0;
    logic [N-1:0]  ch_en = '0;
    logic          resync_req = 1'b0;
    logic          resync_ack;
    logic [N-1:0]  BUFDIV_CE;
    logic [N-1:0]  BUFDIV_CLR;
    logic          mmcm_cdcm_locked_level2;
    logic          seq_busy;
`ifdef BUFG_CLR_SEQ_STATUS_EN
    logic [15:0]   relock_cnt;
    logic          lock_lost;
`endif

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    // Observed vector: {CE, CLR, busy, level2, ack}
    logic [2*N+2:0] obs;
    assign obs = {BUFDIV_CE, BUFDIV_CLR, seq_busy, mmcm_cdcm_locked_level2, resync_ack};

    always #5 clk_CLR = ~clk_CLR;

    bufg_clr_seq #(
        .N_CH          (N),
        .SYNC_STAGES   (SYNC),
        .CE_LOW_CYCLES (CEL),
        .CLR_OFFSET    (CO),
        .LOCK_HOLD     (LH),
        .OUT_PIPE      (OP)
    ) dut (
        .clk_CLR                 (clk_CLR),
        .rst                     (rst),
        .mmcm_cdcm_locked        (mmcm_cdcm_locked),
        .ch_en                   (ch_en),
        .resync_req              (resync_req),
        .resync_ack              (resync_ack),
        .BUFDIV_CE               (BUFDIV_CE),
        .BUFDIV_CLR              (BUFDIV_CLR),
        .mmcm_cdcm_locked_level2 (mmcm_cdcm_locked_level2),
        .seq_busy                (seq_busy)
`ifdef BUFG_CLR_SEQ_STATUS_EN
        ,
        .relock_cnt              (relock_cnt),
        .lock_lost               (lock_lost)
`endif
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_CLR);
        #1;
        cyc++;
    endtask

    // Expected {CE, CLR, busy, level2} at sample t for a sequence whose first
    // gate cycle is g, aborted at cycle a (first cycle no longer sequencing).
    function automatic logic [2*N+1:0] model(input int t, input int g, input int a,
                                             input logic [N-1:0] en);
        int s;
        logic [N-1:0] ce;
        logic [N-1:0] clr;
        logic busy;
        logic lvl;
        s    = t - OP;
        ce   = (s >= g && s < g + CEL && s < a) ? ~en : '1;
        clr  = (s == g + CO && s < a) ? en : '0;
        busy = (t >= g && t < g + CEL + LH && t < a);
        lvl  = (t >= g + CEL + LH && t < a);
        return {ce, clr, busy, lvl};
    endfunction

    task automatic test_reset();
        logic [2*N+2:0] e;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", obs, {(2*N+3){1'b0}});
        end
        repeat (3) step();
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_held got=%h exp=%h", obs, {(2*N+3){1'b0}});
        end
        rst = 1'b0;
        for (int t = 1; t <= OP + 1; t++) begin
            step();
            e = '0;
            if (t >= OP) e[2*N+2 -: N] = '1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_release t=%0d got=%h exp=%h", t, obs, e);
            end
        end
    endtask

    task automatic test_sequence(input logic [N-1:0] en_in, input bit rand_en);
        logic [N-1:0] en;
        int r;
        int g;
        en = rand_en ? N'($urandom) : en_in;
        ch_en = en;
        mmcm_cdcm_locked = 1'b1;
        r = cyc;
        g = r + SYNC + 1;
        while (cyc < g + CEL + LH + 3) begin
            step();
            total++;
            if (obs !== {model(cyc, g, NEVER, en), 1'b0}) begin
                bad++;
                $display("FAIL seq_window en=%h idx=%0d got=%h exp=%h",
                         en, cyc - g, obs, {model(cyc, g, NEVER, en), 1'b0});
            end
            if (cyc == g) ch_en = ~en;
        end
        mmcm_cdcm_locked = 1'b0;
        #1;
        total++;
        if (mmcm_cdcm_locked_level2 !== 1'b0) begin
            bad++;
            $display("FAIL level2_drop got=%b exp=0", mmcm_cdcm_locked_level2);
        end
        repeat (SYNC + 3) step();
        total++;
        if (BUFDIV_CE !== '1 || seq_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_drop ce=%h busy=%b exp ce=%h busy=0", BUFDIV_CE, seq_busy, {N{1'b1}});
        end
    endtask

    task automatic test_lock_drop(input int d);
        logic [N-1:0] en;
        int r;
        int g;
        int k;
        int a;
        for (int pass = 0; pass < 2; pass++) begin
            en = N'($urandom);
            ch_en = en;
            mmcm_cdcm_locked = 1'b1;
            r = cyc;
            g = r + SYNC + 1;
            k = (pass == 0) ? g + d - SYNC : NEVER;
            a = (pass == 0) ? g + d + 1 : NEVER;
            while (cyc < g + CEL + LH + 3) begin
                step();
                total++;
                if (obs !== {model(cyc, g, a, en), 1'b0}) begin
                    bad++;
                    $display("FAIL lock_drop pass=%0d d=%0d idx=%0d got=%h exp=%h",
                             pass, d, cyc - g, obs, {model(cyc, g, a, en), 1'b0});
                end
                if (cyc == k) mmcm_cdcm_locked = 1'b0;
            end
        end
        mmcm_cdcm_locked = 1'b0;
        repeat (SYNC + 3) step();
    endtask

    task automatic test_resync();
        logic [N-1:0] en;
        logic [2*N+2:0] e;
        int k;
        int g;
        en = N'($urandom);
        ch_en = en;
        mmcm_cdcm_locked = 1'b1;
        repeat (SYNC + 1 + CEL + LH + 2) step();
        total++;
        if (mmcm_cdcm_locked_level2 !== 1'b1) begin
            bad++;
            $display("FAIL resync_pre_run level2=%b exp=1", mmcm_cdcm_locked_level2);
        end
        en = N'($urandom);
        ch_en = en;
        resync_req = 1'b1;
        k = cyc;
        g = k + 2;
        while (cyc < k + 30) begin
            step();
            e = {model(cyc, g, NEVER, en), (cyc == g + CEL + LH)};
            if (cyc < g) e[1] = 1'b1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL resync idx=%0d got=%h exp=%h", cyc - g, obs, e);
            end
            if (cyc == k + 20) resync_req = 1'b0;
        end
        mmcm_cdcm_locked = 1'b0;
        repeat (SYNC + 3) step();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] en;
        int r;
        int g;
        en = N'($urandom);
        ch_en = en;
        mmcm_cdcm_locked = 1'b1;
        r = cyc;
        g = r + SYNC + 1;
        while (cyc < g + CEL + LH + 12) begin
            step();
            total++;
            if (obs !== {model(cyc, g, NEVER, en), 1'b0}) begin
                bad++;
                $display("FAIL back_to_back idx=%0d got=%h exp=%h",
                         cyc - g, obs, {model(cyc, g, NEVER, en), 1'b0});
            end
            if (cyc == g - 2) resync_req = 1'b1;
            if (cyc == g + 2) resync_req = 1'b0;
            if (cyc == g + 3) resync_req = 1'b1;
        end
        resync_req = 1'b0;
        mmcm_cdcm_locked = 1'b0;
        repeat (SYNC + 3) step();
    endtask

    task automatic test_rst_mid();
        logic [N-1:0] en;
        int r;
        int g;
        int nclr;
        en = '1;
        ch_en = en;
        mmcm_cdcm_locked = 1'b1;
        r = cyc;
        g = r + SYNC + 1;
        while (cyc < g + 1) step();
        total++;
        if (seq_busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_busy got=%b exp=1", seq_busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL rst_mid_async got=%h exp=%h", obs, {(2*N+3){1'b0}});
        end
        repeat (3) begin
            step();
            total++;
            if (BUFDIV_CLR !== '0 || BUFDIV_CE !== '0) begin
                bad++;
                $display("FAIL rst_mid_hold ce=%h clr=%h exp 0 0", BUFDIV_CE, BUFDIV_CLR);
            end
        end
        rst = 1'b0;
        nclr = 0;
        r = cyc;
        g = r + SYNC + 1;
        while (cyc < g + CEL + LH + 3) begin
            step();
            if (BUFDIV_CLR !== '0) nclr++;
            if (cyc >= r + OP) begin
                total++;
                if (obs !== {model(cyc, g, NEVER, en), 1'b0}) begin
                    bad++;
                    $display("FAIL rst_mid_restart idx=%0d got=%h exp=%h",
                             cyc - g, obs, {model(cyc, g, NEVER, en), 1'b0});
                end
            end
        end
        total++;
        if (nclr != 1) begin
            bad++;
            $display("FAIL rst_mid_clr_count got=%0d exp=1", nclr);
        end
        mmcm_cdcm_locked = 1'b0;
        repeat (SYNC + 3) step();
    endtask

`ifdef BUFG_CLR_SEQ_STATUS_EN
    task automatic test_status();
        rst = 1'b1;
        step();
        total++;
        if (relock_cnt !== 16'd0 || lock_lost !== 1'b0) begin
            bad++;
            $display("FAIL status_reset cnt=%h lost=%b exp 0000 0", relock_cnt, lock_lost);
        end
        rst = 1'b0;
        ch_en = N'($urandom);
        repeat (3) begin
            mmcm_cdcm_locked = 1'b1;
            repeat (SYNC + 1 + CEL + LH + 3) step();
            mmcm_cdcm_locked = 1'b0;
            repeat (SYNC + 3) step();
        end
        total++;
        if (relock_cnt !== 16'd3 || lock_lost !== 1'b1) begin
            bad++;
            $display("FAIL status_count cnt=%h lost=%b exp 0003 1", relock_cnt, lock_lost);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence(4'hF, 1'b0);
        test_sequence(4'b0101, 1'b0);
        repeat (4) test_sequence('0, 1'b1);
        test_lock_drop(3);
        repeat (3) test_lock_drop(int'($urandom_range(0, CEL + LH - 1)));
        test_resync();
        test_back_to_back();
        test_rst_mid();
`ifdef BUFG_CLR_SEQ_STATUS_EN
        test_status();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
